// File: rtl/mst_req_queue.sv
// mst_req_queue: buffers requester transactions in a DEPTH-entry FIFO and issues them one at a time to a crossbar master port.
// Latency: push into an idle, empty queue raises req after 2 edges; ack at edge M puts the next head on the bus and rsp_valid after edge M.
// Backpressure: in_ready drops while DEPTH entries are queued; req fields hold until ack (or, with MRQ_TIMEOUT_EN, until TIMEOUT cycles pass).

// Generic pointer-based FIFO; head entry is visible combinationally.
module mst_req_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push_vld,
   input  logic [W-1:0]            push_dat,
   input  logic                    pop,
   output logic [W-1:0]            head_dat,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [PW:0]  wr_ptr;
   logic [PW:0]  rd_ptr;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign count    = wr_ptr - rd_ptr;
   assign head_dat = mem[rd_ptr[PW-1:0]];

   // Pointer update; both pointers wrap naturally modulo 2*DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_vld && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)     rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push_vld && !full) mem[wr_ptr[PW-1:0]] <= push_dat;
   end
endmodule

module mst_req_queue #(
   parameter int DEPTH   = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [AW-1:0]           in_addr,
   input  logic                    in_cmd,
   input  logic [DW-1:0]           in_wdata,
   output logic                    req,
   output logic [AW-1:0]           addr,
   output logic                    cmd,
   output logic [DW-1:0]           wdata,
   input  logic                    ack,
   input  logic [DW-1:0]           rdata,
   output logic                    rsp_valid,
   output logic [DW-1:0]           rsp_rdata,
   output logic                    rsp_err,
   output logic [$clog2(DEPTH):0]  level
);
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
      $error("mst_req_queue: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
   end

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          cmd;
      logic [DW-1:0] wdata;
   } txn_t;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state;
   state_t state_nxt;
   txn_t   push_dat;
   txn_t   head_dat;
   logic   fifo_empty;
   logic   fifo_full;
   logic   push;
   logic   pop;
   logic   done;
   logic   timeout_hit;

   assign push_dat = '{addr: in_addr, cmd: in_cmd, wdata: in_wdata};
   assign in_ready = !fifo_full;
   assign push     = in_valid && in_ready;
   assign req      = (state == BUSY);

   // A transfer ends on ack; a timeout abort ends it the same way.
   assign done = (state == BUSY) && (ack || timeout_hit);
   // Load a new head when idle, or back-to-back as the current transfer ends.
   assign pop  = !fifo_empty && ((state == IDLE) || done);

   mst_req_fifo #(.DEPTH(DEPTH), .W($bits(txn_t))) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (push),
      .push_dat (push_dat),
      .pop      (pop),
      .head_dat (head_dat),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .count    (level)
   );

`ifdef MRQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] to_cnt;
   logic          rsp_err_q;

   // Abort on the BUSY cycle that would bring the no-ack count up to TIMEOUT; ack wins.
   assign timeout_hit = (state == BUSY) && !ack && (to_cnt == TW'(TIMEOUT - 1));
   assign rsp_err     = rsp_err_q;

   // Count BUSY cycles without ack; every newly loaded transaction starts from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt <= '0;
      end else if (pop) begin
         to_cnt <= '0;
      end else if ((state == BUSY) && !ack) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign rsp_err     = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state: stay BUSY while there is a follow-on transaction to issue.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!fifo_empty)            state_nxt = BUSY;
         BUSY:    if (done && fifo_empty)     state_nxt = IDLE;
         default:                             state_nxt = IDLE;
      endcase
   end

   // Crossbar-side registers: loaded only on pop, so fields stay stable while waiting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr  <= '0;
         cmd   <= 1'b0;
         wdata <= '0;
      end else if (pop) begin
         addr  <= head_dat.addr;
         cmd   <= head_dat.cmd;
         wdata <= head_dat.wdata;
      end
   end

   // Response: one-cycle pulse after a read ack (or after an abort); write acks stay silent.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
`ifdef MRQ_TIMEOUT_EN
         rsp_err_q <= 1'b0;
`endif
      end else begin
         rsp_valid <= 1'b0;
`ifdef MRQ_TIMEOUT_EN
         rsp_err_q <= 1'b0;
`endif
         if ((state == BUSY) && ack && !cmd) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata;
         end
`ifdef MRQ_TIMEOUT_EN
         else if (timeout_hit) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err_q <= 1'b1;
         end
`endif
      end
   end
endmodule

// File: tb/tb_mst_req_queue.sv
// Bench for mst_req_queue: random requester and ack stimulus, queue-based reference, scoreboard monitor.
// Expected bus order and occupancy come from the accepted-push queue; read responses are scored one cycle after ack.
// Includes an asynchronous reset while BUSY with three queued entries.
module tb_mst_req_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_addr;
   logic          in_cmd;
   logic [DW-1:0] in_wdata;
   logic          req;
   logic [AW-1:0] addr;
   logic          cmd;
   logic [DW-1:0] wdata;
   logic          ack;
   logic [DW-1:0] rdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic [LW-1:0] level;

   mst_req_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .TIMEOUT(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .in_cmd    (in_cmd),
      .in_wdata  (in_wdata),
      .req       (req),
      .addr      (addr),
      .cmd       (cmd),
      .wdata     (wdata),
      .ack       (ack),
      .rdata     (rdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .level     (level)
   );

   typedef struct {
      logic [AW-1:0] a;
      logic          c;
      logic [DW-1:0] d;
   } txn_t;

   txn_t          exp_bus[$];   // accepted transactions not yet on the bus
   logic [DW-1:0] exp_rsp[$];   // read data owed to the response port
   int            n_chk = 0;
   int            n_fail = 0;
   int            vld_pct = 0;
   int            ack_pct = 0;
   bit            drv_en = 0;
   bit            mon_en = 0;
   bit            force_ack = 0;
   bit            accepted = 0;
   logic          prev_req = 0;
   txn_t          cur;
   bit            cur_ok = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic err(input string nm, input int act, input int exp);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   task automatic run_phase(input int v, input int a, input int n);
      vld_pct = v;
      ack_pct = a;
      repeat (n) @(negedge clk);
   endtask

   // Reference acceptance: a push lands when offered and fewer than DEPTH entries wait.
   always @(posedge clk) begin
      accepted = 0;
      if (drv_en && !reset && in_valid && exp_bus.size() < DEPTH) begin
         accepted = 1;
         exp_bus.push_back('{a: in_addr, c: in_cmd, d: in_wdata});
      end
   end

   // Requester and crossbar stimulus, driven on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!drv_en) begin
            in_valid = 1'b0;
         end else if (!in_valid || accepted) begin
            in_valid = (int'($urandom_range(99)) < vld_pct);
            in_addr  = $urandom;
            in_cmd   = 1'($urandom_range(1));
            in_wdata = $urandom;
         end
         if (force_ack)  ack = 1'b1;
         else if (req)   ack = (int'($urandom_range(99)) < ack_pct);
         else            ack = ($urandom_range(9) == 0);
         rdata = $urandom;
      end
   end

   // Scoreboard monitor, sampling 1ns after each rising edge.
   always begin
      @(posedge clk);
      #1;
      if (!mon_en) begin
         prev_req = 1'b0;
         cur_ok   = 0;
      end else begin
         bit done_e;
         bit rd_done;
         bit new_txn;
         logic [DW-1:0] e;
         done_e  = prev_req && ack;
         rd_done = done_e && cur_ok && !cur.c;
         if (rd_done) exp_rsp.push_back(rdata);
         chk("rsp_valid", rsp_valid, rd_done);
         if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
               err("rsp_unexpected", 1, 0);
            end else begin
               e = exp_rsp.pop_front();
               chk("rsp_rdata", rsp_rdata, e);
               chk("rsp_err", rsp_err, 0);
            end
         end
         new_txn = req && (!prev_req || ack);
         if (new_txn) begin
            if (exp_bus.size() == 0) begin
               err("req_without_entry", 1, 0);
               cur_ok = 0;
            end else begin
               cur    = exp_bus.pop_front();
               cur_ok = 1;
               chk("bus_addr", addr, cur.a);
               chk("bus_cmd", cmd, cur.c);
               chk("bus_wdata", wdata, cur.d);
            end
         end else if (req && cur_ok) begin
            chk("hold_addr", addr, cur.a);
            chk("hold_cmd", cmd, cur.c);
            chk("hold_wdata", wdata, cur.d);
         end
         if (!req) cur_ok = 0;
         chk("level", level, exp_bus.size());
         chk("in_ready", in_ready, exp_bus.size() < DEPTH);
         prev_req = req;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_addr  = '0;
      in_cmd   = 1'b0;
      in_wdata = '0;
      ack      = 1'b0;
      rdata    = '0;
      repeat (3) @(negedge clk);
      chk("rst_req", req, 0);
      chk("rst_addr", addr, 0);
      chk("rst_cmd", cmd, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_level", level, 0);
      chk("rst_in_ready", in_ready, 1);
      reset  = 1'b0;
      mon_en = 1;
      drv_en = 1;

      run_phase(60, 50, 300);
      run_phase(100, 100, 200);   // ack held high: back-to-back issue
      run_phase(100, 0, 15);      // no ack: fill to full, pushes refused
      run_phase(100, 30, 200);
      run_phase(30, 100, 200);
      run_phase(80, 70, 300);

      // Asynchronous reset while BUSY with three queued entries.
      vld_pct = 100;
      ack_pct = 0;
      for (int i = 0; i < 40 && !(exp_bus.size() == 3 && req); i++) @(negedge clk);
      if (!(exp_bus.size() == 3 && req)) err("reach_level3", exp_bus.size(), 3);
      drv_en = 0;
      mon_en = 0;
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_req", req, 0);
      chk("async_rst_level", level, 0);
      chk("async_rst_in_ready", in_ready, 1);
      exp_bus.delete();
      exp_rsp.delete();
      @(negedge clk);
      reset     = 1'b0;
      force_ack = 1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_req", req, 0);
         chk("post_rst_rsp_valid", rsp_valid, 0);
         chk("post_rst_level", level, 0);
      end
      force_ack = 0;
      mon_en    = 1;
      drv_en    = 1;
      run_phase(70, 50, 300);

      // Drain everything still queued or in flight.
      vld_pct = 0;
      ack_pct = 100;
      for (int i = 0; i < 100 && !(exp_bus.size() == 0 && !req && !in_valid); i++) @(negedge clk);
      if (!(exp_bus.size() == 0 && !req)) err("drain", exp_bus.size(), 0);
      repeat (3) @(negedge clk);
      chk("rsp_leftover", exp_rsp.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
